wbu: RTL and testbench

- Write-back stage; sits directly downstream of the load/store stage and is the last pipeline stage.
- Registers the load/store stage's results through a valid/ready stage register, selects the load result or the execute result, and writes the GPR file and CSR file.
- Raises a fence.i redirect, counts retired instructions, and provides bypass data to the decode/execute forwarding logic.
- Retirement is gated by a commit handshake; that port is held by the sim/difftest harness and tied ready in synthesis.

---
 rtl/wbu.sv | 164 ++++++++++++++++
 tb/tb_wbu.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbu.sv
// wbu - write-back stage, the last stage of the pipeline.
//
// Captures the load/store stage result through a valid/ready stage register,
// picks the load or execute result, and drives the GPR and CSR write ports
// once the instruction retires through the commit handshake. Also provides
// forwarding data, a one-cycle fence.i redirect and a retired-instruction
// counter.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_flush               synchronous flush of the stage register
//   i_pre_valid/o_pre_ready  upstream handshake
//   i_lsu_*               load/store stage payload
//   o_commit_*/i_commit_ready  retirement handshake (pc/ins always driven)
//   o_rf_*                GPR write port (x0 writes suppressed)
//   o_csr_*               CSR write port
//   o_wbu_*               forwarding data, valid even while commit stalls
//   o_fencei_redir/o_redir_pc  fence.i redirect pulse and target (pc + 4)
//   o_instret             retired-instruction count (bubbles excluded)
module wbu #(
    parameter int unsigned CPU_WIDTH = 64,
    parameter int unsigned REG_ADDRW = 5,
    parameter int unsigned CSR_ADDRW = 12,
    parameter int unsigned INS_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    input  logic                 i_pre_valid,
    output logic                 o_pre_ready,
    input  logic [CPU_WIDTH-1:0] i_lsu_lsres,
    input  logic [CPU_WIDTH-1:0] i_lsu_exres,
    input  logic                 i_lsu_lden,
    input  logic                 i_lsu_fencei,
    input  logic [REG_ADDRW-1:0] i_lsu_rdid,
    input  logic                 i_lsu_rdwen,
    input  logic [CSR_ADDRW-1:0] i_lsu_csrdid,
    input  logic                 i_lsu_csrdwen,
    input  logic [CPU_WIDTH-1:0] i_lsu_csrd,
    input  logic [CPU_WIDTH-1:0] i_lsu_pc,
    input  logic [INS_WIDTH-1:0] i_lsu_ins,
    input  logic                 i_lsu_nop,
    output logic                 o_commit_valid,
    input  logic                 i_commit_ready,
    output logic [CPU_WIDTH-1:0] o_commit_pc,
    output logic [INS_WIDTH-1:0] o_commit_ins,
    output logic                 o_rf_wen,
    output logic [REG_ADDRW-1:0] o_rf_waddr,
    output logic [CPU_WIDTH-1:0] o_rf_wdata,
    output logic                 o_csr_wen,
    output logic [CSR_ADDRW-1:0] o_csr_waddr,
    output logic [CPU_WIDTH-1:0] o_csr_wdata,
    output logic [REG_ADDRW-1:0] o_wbu_rdid,
    output logic                 o_wbu_rdwen,
    output logic [CPU_WIDTH-1:0] o_wbu_rd,
    output logic                 o_fencei_redir,
    output logic [CPU_WIDTH-1:0] o_redir_pc,
    output logic [63:0]          o_instret
);

    logic                 valid_q, valid_d, valid_en;
    logic                 pay_en;
    logic [CPU_WIDTH-1:0] lsres_q, exres_q, csrd_q, pc_q;
    logic                 lden_q, fencei_q, rdwen_q, csrdwen_q, nop_q;
    logic [REG_ADDRW-1:0] rdid_q;
    logic [CSR_ADDRW-1:0] csrdid_q;
    logic [INS_WIDTH-1:0] ins_q;
    logic [63:0]          instret_q, instret_d;
    logic                 commit_fire;
    logic [CPU_WIDTH-1:0] wdata;

    assign commit_fire = valid_q & i_commit_ready;
    assign o_pre_ready = ~valid_q | commit_fire;
    assign wdata       = lden_q ? lsres_q : exres_q;

    always_comb begin
        valid_en  = i_flush | o_pre_ready;
        valid_d   = i_flush ? 1'b0 : i_pre_valid;
        // Flush loads zeros, so it must win over a simultaneous capture.
        pay_en    = i_flush | (i_pre_valid & o_pre_ready);
        instret_d = instret_q;
        if (commit_fire && !nop_q) begin
            instret_d = instret_q + 64'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            if (valid_en) begin
                valid_q <= valid_d;
            end
            instret_q <= instret_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lsres_q   <= '0;
            exres_q   <= '0;
            lden_q    <= 1'b0;
            fencei_q  <= 1'b0;
            rdid_q    <= '0;
            rdwen_q   <= 1'b0;
            csrdid_q  <= '0;
            csrdwen_q <= 1'b0;
            csrd_q    <= '0;
            pc_q      <= '0;
            ins_q     <= '0;
            nop_q     <= 1'b0;
        end else if (pay_en) begin
            if (i_flush) begin
                lsres_q   <= '0;
                exres_q   <= '0;
                lden_q    <= 1'b0;
                fencei_q  <= 1'b0;
                rdid_q    <= '0;
                rdwen_q   <= 1'b0;
                csrdid_q  <= '0;
                csrdwen_q <= 1'b0;
                csrd_q    <= '0;
                pc_q      <= '0;
                ins_q     <= '0;
                nop_q     <= 1'b0;
            end else begin
                lsres_q   <= i_lsu_lsres;
                exres_q   <= i_lsu_exres;
                lden_q    <= i_lsu_lden;
                fencei_q  <= i_lsu_fencei;
                rdid_q    <= i_lsu_rdid;
                rdwen_q   <= i_lsu_rdwen;
                csrdid_q  <= i_lsu_csrdid;
                csrdwen_q <= i_lsu_csrdwen;
                csrd_q    <= i_lsu_csrd;
                pc_q      <= i_lsu_pc;
                ins_q     <= i_lsu_ins;
                nop_q     <= i_lsu_nop;
            end
        end
    end

    always_comb begin
        o_commit_valid = valid_q;
        o_commit_pc    = pc_q;
        o_commit_ins   = ins_q;
        o_rf_wen       = commit_fire & rdwen_q & (rdid_q != '0);
        o_rf_waddr     = rdid_q;
        o_rf_wdata     = wdata;
        o_csr_wen      = commit_fire & csrdwen_q;
        o_csr_waddr    = csrdid_q;
        o_csr_wdata    = csrd_q;
        // Forwarding must see a result that is stalled on commit.
        o_wbu_rdwen    = valid_q & rdwen_q;
        o_wbu_rdid     = rdid_q;
        o_wbu_rd       = wdata;
        // The register moves on at the firing edge, so this is a single pulse.
        o_fencei_redir = commit_fire & fencei_q;
        o_redir_pc     = pc_q + CPU_WIDTH'(4);
        o_instret      = instret_q;
    end

endmodule

// File: tb/tb_wbu.sv
module tb_wbu;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_flush;
    logic        i_pre_valid;
    logic        o_pre_ready;
    logic [63:0] i_lsu_lsres, i_lsu_exres, i_lsu_csrd, i_lsu_pc;
    logic        i_lsu_lden, i_lsu_fencei, i_lsu_rdwen, i_lsu_csrdwen, i_lsu_nop;
    logic [4:0]  i_lsu_rdid;
    logic [11:0] i_lsu_csrdid;
    logic [31:0] i_lsu_ins;
    logic        o_commit_valid, i_commit_ready;
    logic [63:0] o_commit_pc;
    logic [31:0] o_commit_ins;
    logic        o_rf_wen;
    logic [4:0]  o_rf_waddr;
    logic [63:0] o_rf_wdata;
    logic        o_csr_wen;
    logic [11:0] o_csr_waddr;
    logic [63:0] o_csr_wdata;
    logic [4:0]  o_wbu_rdid;
    logic        o_wbu_rdwen;
    logic [63:0] o_wbu_rd;
    logic        o_fencei_redir;
    logic [63:0] o_redir_pc;
    logic [63:0] o_instret;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    wbu dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_flush        (i_flush),
        .i_pre_valid    (i_pre_valid),
        .o_pre_ready    (o_pre_ready),
        .i_lsu_lsres    (i_lsu_lsres),
        .i_lsu_exres    (i_lsu_exres),
        .i_lsu_lden     (i_lsu_lden),
        .i_lsu_fencei   (i_lsu_fencei),
        .i_lsu_rdid     (i_lsu_rdid),
        .i_lsu_rdwen    (i_lsu_rdwen),
        .i_lsu_csrdid   (i_lsu_csrdid),
        .i_lsu_csrdwen  (i_lsu_csrdwen),
        .i_lsu_csrd     (i_lsu_csrd),
        .i_lsu_pc       (i_lsu_pc),
        .i_lsu_ins      (i_lsu_ins),
        .i_lsu_nop      (i_lsu_nop),
        .o_commit_valid (o_commit_valid),
        .i_commit_ready (i_commit_ready),
        .o_commit_pc    (o_commit_pc),
        .o_commit_ins   (o_commit_ins),
        .o_rf_wen       (o_rf_wen),
        .o_rf_waddr     (o_rf_waddr),
        .o_rf_wdata     (o_rf_wdata),
        .o_csr_wen      (o_csr_wen),
        .o_csr_waddr    (o_csr_waddr),
        .o_csr_wdata    (o_csr_wdata),
        .o_wbu_rdid     (o_wbu_rdid),
        .o_wbu_rdwen    (o_wbu_rdwen),
        .o_wbu_rd       (o_wbu_rd),
        .o_fencei_redir (o_fencei_redir),
        .o_redir_pc     (o_redir_pc),
        .o_instret      (o_instret)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [63:0] lsres, input logic [63:0] exres,
                        input logic lden, input logic fencei, input logic [4:0] rdid,
                        input logic rdwen, input logic [11:0] csrdid, input logic csrdwen,
                        input logic [63:0] csrd, input logic [63:0] pc, input logic nop);
        i_pre_valid   = 1'b1;
        i_lsu_lsres   = lsres;
        i_lsu_exres   = exres;
        i_lsu_lden    = lden;
        i_lsu_fencei  = fencei;
        i_lsu_rdid    = rdid;
        i_lsu_rdwen   = rdwen;
        i_lsu_csrdid  = csrdid;
        i_lsu_csrdwen = csrdwen;
        i_lsu_csrd    = csrd;
        i_lsu_pc      = pc;
        i_lsu_ins     = pc[31:0] ^ 32'h0000_0013;
        i_lsu_nop     = nop;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_flush = 1'b0; i_pre_valid = 1'b0; i_commit_ready = 1'b1;
        send(64'd0, 64'd0, 1'b0, 1'b0, 5'd0, 1'b0, 12'd0, 1'b0, 64'd0, 64'd0, 1'b0);
        i_pre_valid = 1'b0;
        #1;
        checks++;
        if (o_commit_valid !== 1'b0 || o_pre_ready !== 1'b1 || o_instret !== 64'd0) begin
            errors++;
            $display("FAIL reset: valid=%b ready=%b instret=%0d, want 0 1 0",
                     o_commit_valid, o_pre_ready, o_instret);
        end
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load();
        send(64'hFFFF_FFFF_FFFF_FF80, 64'h8000_0010, 1'b1, 1'b0, 5'd5, 1'b1, 12'd0, 1'b0,
             64'd0, 64'h8000_0000, 1'b0);
        tick();
        i_pre_valid = 1'b0;
        checks++;
        if (o_rf_wen !== 1'b1 || o_rf_waddr !== 5'd5 || o_rf_wdata !== 64'hFFFF_FFFF_FFFF_FF80)
        begin
            errors++;
            $display("FAIL load_write: wen=%b addr=%0d data=%h, want 1 5 ffffffffffffff80",
                     o_rf_wen, o_rf_waddr, o_rf_wdata);
        end
        tick();
        checks++;
        if (o_instret !== 64'd1 || o_rf_wen !== 1'b0) begin
            errors++;
            $display("FAIL load_instret: instret=%0d wen=%b, want 1 0", o_instret, o_rf_wen);
        end
    endtask

    task automatic test_x0();
        send(64'd0, 64'h1234, 1'b0, 1'b0, 5'd0, 1'b1, 12'd0, 1'b0, 64'd0, 64'h8000_0004, 1'b0);
        tick();
        i_pre_valid = 1'b0;
        checks++;
        if (o_rf_wen !== 1'b0 || o_wbu_rdwen !== 1'b1 || o_wbu_rd !== 64'h1234) begin
            errors++;
            $display("FAIL x0_write: wen=%b bypass=%b rd=%h, want 0 1 1234",
                     o_rf_wen, o_wbu_rdwen, o_wbu_rd);
        end
        tick();
        checks++;
        if (o_instret !== 64'd2) begin
            errors++;
            $display("FAIL x0_instret: got %0d want 2", o_instret);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] pc0 = 64'h8000_0010;
        for (int i = 1; i <= 3; i++) begin
            send(64'd0, 64'(i * 17), 1'b0, 1'b0, 5'(i), 1'b1, 12'd0, 1'b0, 64'd0,
                 pc0 + 64'(4 * i), 1'b0);
            tick();
            checks++;
            if (o_pre_ready !== 1'b1 || o_rf_wen !== 1'b1 || o_rf_waddr !== 5'(i) ||
                o_rf_wdata !== 64'(i * 17) || o_commit_pc !== pc0 + 64'(4 * i)) begin
                errors++;
                $display("FAIL b2b_%0d: ready=%b wen=%b addr=%0d data=%h pc=%h", i,
                         o_pre_ready, o_rf_wen, o_rf_waddr, o_rf_wdata, o_commit_pc);
            end
        end
        // Third instruction stalls; a fourth waits upstream.
        i_commit_ready = 1'b0;
        send(64'd0, 64'h99, 1'b0, 1'b0, 5'd4, 1'b1, 12'd0, 1'b0, 64'd0, 64'h8000_0020, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (o_pre_ready !== 1'b0 || o_rf_wen !== 1'b0 || o_rf_waddr !== 5'd3 ||
                o_wbu_rdwen !== 1'b1 || o_wbu_rd !== 64'd51 || o_instret !== 64'd4) begin
                errors++;
                $display("FAIL stall_%0d: ready=%b wen=%b addr=%0d byp=%b rd=%h instret=%0d",
                         c, o_pre_ready, o_rf_wen, o_rf_waddr, o_wbu_rdwen, o_wbu_rd,
                         o_instret);
            end
            tick();
        end
        i_pre_valid    = 1'b0;
        i_commit_ready = 1'b1;
        #1;
        checks++;
        if (o_rf_wen !== 1'b1 || o_rf_waddr !== 5'd3) begin
            errors++;
            $display("FAIL stall_release: wen=%b addr=%0d, want 1 3", o_rf_wen, o_rf_waddr);
        end
        tick();
        checks++;
        if (o_instret !== 64'd5 || o_commit_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_instret: instret=%0d valid=%b, want 5 0", o_instret,
                     o_commit_valid);
        end
    endtask

    task automatic test_fencei();
        int pulses = 0;
        i_commit_ready = 1'b0;
        send(64'd0, 64'd0, 1'b0, 1'b1, 5'd0, 1'b0, 12'd0, 1'b0, 64'd0, 64'h8000_0100, 1'b0);
        tick();
        i_pre_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (o_fencei_redir === 1'b1) pulses++;
            tick();
        end
        i_commit_ready = 1'b1;
        #1;
        checks++;
        if (o_fencei_redir !== 1'b1 || o_redir_pc !== 64'h8000_0104) begin
            errors++;
            $display("FAIL fencei_pulse: redir=%b pc=%h, want 1 80000104",
                     o_fencei_redir, o_redir_pc);
        end
        for (int c = 0; c < 4; c++) begin
            if (o_fencei_redir === 1'b1) pulses++;
            tick();
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL fencei_count: got %0d pulses want 1", pulses);
        end
    endtask

    task automatic test_csr_flush();
        send(64'd0, 64'd0, 1'b0, 1'b0, 5'd0, 1'b0, 12'h305, 1'b1, 64'h8000_0000,
             64'h8000_0200, 1'b0);
        tick();
        i_pre_valid = 1'b0;
        checks++;
        if (o_csr_wen !== 1'b1 || o_csr_waddr !== 12'h305 || o_csr_wdata !== 64'h8000_0000)
        begin
            errors++;
            $display("FAIL csr_write: wen=%b addr=%h data=%h, want 1 305 80000000",
                     o_csr_wen, o_csr_waddr, o_csr_wdata);
        end
        tick();
        checks++;
        if (o_csr_wen !== 1'b0 || o_instret !== 64'd7) begin
            errors++;
            $display("FAIL csr_once: wen=%b instret=%0d, want 0 7", o_csr_wen, o_instret);
        end
        // Same CSR write stalled, then flushed.
        i_commit_ready = 1'b0;
        send(64'd0, 64'd0, 1'b0, 1'b0, 5'd0, 1'b0, 12'h305, 1'b1, 64'h8000_0000,
             64'h8000_0204, 1'b0);
        tick();
        i_pre_valid = 1'b0;
        i_flush     = 1'b1;
        tick();
        i_flush        = 1'b0;
        i_commit_ready = 1'b1;
        #1;
        checks++;
        if (o_csr_wen !== 1'b0 || o_commit_valid !== 1'b0 || o_commit_pc !== 64'd0 ||
            o_instret !== 64'd7) begin
            errors++;
            $display("FAIL csr_flush: wen=%b valid=%b pc=%h instret=%0d, want 0 0 0 7",
                     o_csr_wen, o_commit_valid, o_commit_pc, o_instret);
        end
        // Flush beats a simultaneous capture.
        send(64'd0, 64'h77, 1'b0, 1'b0, 5'd9, 1'b1, 12'd0, 1'b0, 64'd0, 64'h8000_0300, 1'b0);
        i_flush = 1'b1;
        tick();
        i_flush     = 1'b0;
        i_pre_valid = 1'b0;
        checks++;
        if (o_commit_valid !== 1'b0 || o_rf_wen !== 1'b0) begin
            errors++;
            $display("FAIL flush_capture: valid=%b wen=%b, want 0 0", o_commit_valid,
                     o_rf_wen);
        end
        // Flush in the commit cycle: writes and count still happen.
        send(64'd0, 64'h66, 1'b0, 1'b0, 5'd6, 1'b1, 12'd0, 1'b0, 64'd0, 64'h8000_0400, 1'b0);
        tick();
        i_pre_valid = 1'b0;
        i_flush     = 1'b1;
        #1;
        checks++;
        if (o_rf_wen !== 1'b1 || o_rf_waddr !== 5'd6) begin
            errors++;
            $display("FAIL flush_fire: wen=%b addr=%0d, want 1 6", o_rf_wen, o_rf_waddr);
        end
        tick();
        i_flush = 1'b0;
        checks++;
        if (o_commit_valid !== 1'b0 || o_instret !== 64'd8) begin
            errors++;
            $display("FAIL flush_fire_count: valid=%b instret=%0d, want 0 8",
                     o_commit_valid, o_instret);
        end
    endtask

    task automatic test_nop_and_async_reset();
        send(64'd0, 64'd0, 1'b0, 1'b0, 5'd0, 1'b0, 12'd0, 1'b0, 64'd0, 64'h8000_0500, 1'b1);
        tick();
        i_pre_valid = 1'b0;
        checks++;
        if (o_commit_valid !== 1'b1) begin
            errors++;
            $display("FAIL nop_valid: got %b want 1", o_commit_valid);
        end
        tick();
        checks++;
        if (o_instret !== 64'd8) begin
            errors++;
            $display("FAIL nop_instret: got %0d want 8", o_instret);
        end
        i_commit_ready = 1'b0;
        send(64'd0, 64'h55, 1'b0, 1'b0, 5'd7, 1'b1, 12'd0, 1'b0, 64'd0, 64'h8000_0600, 1'b0);
        tick();
        i_pre_valid = 1'b0;
        #1;
        i_commit_ready = 1'b1;
        #1;
        checks++;
        if (o_rf_wen !== 1'b1 || o_wbu_rdwen !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: wen=%b byp=%b, want 1 1", o_rf_wen, o_wbu_rdwen);
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_rf_wen !== 1'b0 || o_wbu_rdwen !== 1'b0 || o_commit_valid !== 1'b0 ||
            o_commit_pc !== 64'd0 || o_instret !== 64'd0 || o_pre_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: wen=%b byp=%b valid=%b pc=%h instret=%0d ready=%b",
                     o_rf_wen, o_wbu_rdwen, o_commit_valid, o_commit_pc, o_instret,
                     o_pre_ready);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load();
        test_x0();
        test_back_to_back();
        test_fencei();
        test_csr_flush();
        test_nop_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
